baud_tick_gen: RTL
==================

# baud_tick_gen

Parametrised fractional baud-rate tick generator for the UART TX/RX datapaths. Produces an oversampling tick, a once-per-bit tick and a mid-bit sample tick from a run-time programmable divider. The divider has an integer part and a fractional part, and a programmable oversampling ratio. Configuration is double-buffered so it can change while running without producing a truncated bit period.

## Interface
- INT_W, 16: width of the integer divisor
- FRAC_W, 4: width of the fractional divisor (1/2^FRAC_W clock resolution)
- OSR_W, 5: width of the oversampling field (ratio up to 2^OSR_W)
- DEF_INT, 650: reset value of the active integer divisor
- DEF_OSR, 15: reset value of the active oversample field (ratio 16)

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- enable  in  1  run the generator; low clears counters
- cfg_int  in  INT_W  sample period minus 1, in clocks
- cfg_frac  in  FRAC_W  fractional clock addend per sample period
- cfg_osr  in  OSR_W  samples per bit minus 1
- cfg_load  in  1  one-cycle strobe capturing cfg_*
- cfg_pending  out  1  captured config not yet active
- sample_tick  out  1  one-cycle oversample pulse
- mid_tick  out  1  one-cycle pulse at the mid-bit sample
- bit_tick  out  1  one-cycle pulse at the last sample of a bit
- phase  out  OSR_W  index of the current sample within the bit

## Operation
- Active config registers: act_int, act_frac, act_osr. Pending registers: pend_*, plus pend_valid, which drives cfg_pending.
- Divider: div_cnt counts 0..end, where end = act_int + carry.
  - sample_tick fires on the wrap of div_cnt.
  - carry is the overflow of (frac_acc + act_frac), evaluated once per period.
  - frac_acc is updated modulo 2^FRAC_W at each wrap.
  - Average period is act_int + 1 + act_frac/2^FRAC_W clocks.
- Phase: phase increments on each sample_tick and wraps from act_osr to 0.
  - bit_tick = sample_tick with phase == act_osr.
  - mid_tick = sample_tick with phase == act_osr>>1 (floor).
  - act_osr = 0: bit_tick and mid_tick coincide with every sample_tick.
- Config loading:
  - cfg_load with enable low: act_* loaded next edge; pend_valid stays 0.
  - cfg_load with enable high: pend_* captured and pend_valid = 1. Pending config is moved to act_* on the edge where bit_tick fires, and pend_valid clears.
  - Repeated cfg_load while pending: last write wins.
  - cfg_load in the same cycle as bit_tick: the newly presented cfg_* goes straight into act_*; no pending state.
  - enable falling while pend_valid = 1: pending applied on the next edge.
- enable low: div_cnt, frac_acc and phase are cleared; all tick outputs are 0.
- cfg_int = 0: allowed. The period is 1 clock, or 2 on a carry.

## Timing
- Reset (rst high at an edge): div_cnt, frac_acc, phase, pend_valid = 0; act_int = DEF_INT, act_frac = 0, act_osr = DEF_OSR. All outputs read 0 (phase 0) the cycle after reset.
- Ticks are registered outputs.
  - With frac = 0, the first sample_tick is visible act_int+1 cycles after the first edge that samples enable = 1.
  - Subsequent sample_ticks are exactly act_int+1 cycles apart.
- phase updates on the same edge that asserts sample_tick; it shows the index of the sample being flagged.
- rst mid-bit overrides everything, including a simultaneous cfg_load.
- enable dropped mid-bit: ticks are low from the next cycle. Re-enable restarts from div_cnt = 0, phase = 0, frac_acc = 0.

## Configuration
- BAUD_TICK_FRAC_EN defined: frac_acc and cfg_frac are honoured.
- Not defined:
  - cfg_frac port stays present but is ignored.
  - frac_acc and the carry logic are removed; carry = 0.
  - The period is exactly act_int+1.

## Structure
- Package baud_pkg holds:
  - Width constants (INT_W, FRAC_W, OSR_W defaults).
  - DEF_INT and DEF_OSR.
  - A cfg struct typedef {int, frac, osr} used for both the act and pend registers.
- Sub-module frac_divider (div_cnt + frac_acc → sample_tick) is instantiated once. Phase, tick decode and config buffering stay in the top level.

## Test plan
- Reset then enable with cfg_int = 3, frac = 0, osr = 3: sample_tick every 4 clocks, first one 4 cycles after enable; bit_tick every 16 clocks; mid_tick at phase 1.
- cfg_int = 4, cfg_frac = 8, FRAC_W = 4, macro on: periods alternate 5, 6 clocks; 16 samples take 88 clocks. With the macro off: 80 clocks.
- cfg_load of int = 1 mid-bit while running with int = 3: cfg_pending = 1 until the next bit_tick. The old period holds through that bit, then 2-clock periods; cfg_pending returns to 0.
- cfg_load in the same cycle as bit_tick: new period is used immediately; cfg_pending never asserts.
- enable dropped at phase 5, then raised 3 cycles later: no ticks while low; the restart's first sample_tick reports phase 0 after act_int+1 cycles.
- rst pulsed mid-bit with cfg_load high: act_int = DEF_INT, act_osr = DEF_OSR, cfg_pending = 0, all ticks 0.

Source files
------------

// File: rtl/baud_pkg.sv
// Shared widths, reset defaults and the divider config record for baud_tick_gen.
package baud_pkg;

    localparam int INT_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OSR_W  = 5;

    localparam logic [INT_W-1:0] DEF_INT = 16'd650;
    localparam logic [OSR_W-1:0] DEF_OSR = 5'd15;

    // One record type serves both the active and the pending register banks.
    typedef struct packed {
        logic [INT_W-1:0]  div_int;
        logic [FRAC_W-1:0] div_frac;
        logic [OSR_W-1:0]  osr;
    } cfg_t;

    function automatic cfg_t cfg_default();
        return '{div_int: DEF_INT, div_frac: '0, osr: DEF_OSR};
    endfunction

endpackage

// File: rtl/baud_tick_gen_frac_divider.sv
// Sample-period divider: div_cnt runs 0..div_int+carry, wrap marks the last clock.
// BAUD_TICK_FRAC_EN adds the fractional accumulator; otherwise carry is tied to 0.
module frac_divider #(
    parameter int INT_W  = baud_pkg::INT_W,
    parameter int FRAC_W = baud_pkg::FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [INT_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              wrap,
    output logic              sample_tick
);

    // One extra bit so div_int at full scale plus a carry cannot overflow.
    logic [INT_W:0] div_cnt;
    logic [INT_W:0] cnt_end;
    logic           carry;

`ifdef BAUD_TICK_FRAC_EN
    logic [FRAC_W-1:0] frac_acc;
    logic [FRAC_W:0]   frac_sum;

    assign frac_sum = {1'b0, frac_acc} + {1'b0, div_frac};
    assign carry    = frac_sum[FRAC_W];

    // The accumulator only moves at a wrap, so carry is constant across a period.
    always_ff @(posedge clk) begin
        if (rst || !enable)
            frac_acc <= '0;
        else if (wrap)
            frac_acc <= frac_sum[FRAC_W-1:0];
    end
`else
    logic unused_frac;
    assign unused_frac = ^div_frac;
    assign carry       = 1'b0;
`endif

    assign cnt_end = {1'b0, div_int} + {{INT_W{1'b0}}, carry};
    assign wrap    = enable && (div_cnt >= cnt_end);

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            div_cnt     <= '0;
            sample_tick <= 1'b0;
        end else begin
            sample_tick <= wrap;
            div_cnt     <= wrap ? '0 : div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/baud_tick_gen.sv
// Fractional baud tick generator: sample/mid/bit ticks with double-buffered config.
// Build option: define BAUD_TICK_FRAC_EN to honour cfg_frac (fractional divider).
module baud_tick_gen #(
    parameter int               INT_W   = baud_pkg::INT_W,
    parameter int               FRAC_W  = baud_pkg::FRAC_W,
    parameter int               OSR_W   = baud_pkg::OSR_W,
    parameter logic [INT_W-1:0] DEF_INT = baud_pkg::DEF_INT,
    parameter logic [OSR_W-1:0] DEF_OSR = baud_pkg::DEF_OSR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [INT_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    input  logic [OSR_W-1:0]  cfg_osr,
    input  logic              cfg_load,
    output logic              cfg_pending,
    output logic              sample_tick,
    output logic              mid_tick,
    output logic              bit_tick,
    output logic [OSR_W-1:0]  phase
);
    import baud_pkg::*;

    cfg_t             act;
    cfg_t             pend;
    cfg_t             cfg_in;
    logic             pend_valid;
    logic [OSR_W-1:0] nxt_idx;
    logic             wrap;
    logic             bit_evt;
    logic             mid_evt;

    assign cfg_in      = '{div_int: cfg_int, div_frac: cfg_frac, osr: cfg_osr};
    assign cfg_pending = pend_valid;

    frac_divider #(
        .INT_W  (INT_W),
        .FRAC_W (FRAC_W)
    ) u_div (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .div_int     (act.div_int),
        .div_frac    (act.div_frac),
        .wrap        (wrap),
        .sample_tick (sample_tick)
    );

    // nxt_idx is the index of the sample about to be flagged; phase shows the last one.
    assign bit_evt = wrap && (nxt_idx == act.osr);
    assign mid_evt = wrap && (nxt_idx == (act.osr >> 1));

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            nxt_idx  <= '0;
            phase    <= '0;
            bit_tick <= 1'b0;
            mid_tick <= 1'b0;
        end else begin
            bit_tick <= bit_evt;
            mid_tick <= mid_evt;
            if (wrap) begin
                phase   <= nxt_idx;
                nxt_idx <= bit_evt ? '0 : nxt_idx + 1'b1;
            end
        end
    end

    // Config only swaps at a bit boundary or while idle, so a bit is never truncated.
    // A load on the boundary itself bypasses the pending bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            act        <= '{div_int: DEF_INT, div_frac: '0, osr: DEF_OSR};
            pend       <= '0;
            pend_valid <= 1'b0;
        end else if (!enable || bit_evt) begin
            if (cfg_load)
                act <= cfg_in;
            else if (pend_valid)
                act <= pend;
            pend_valid <= 1'b0;
        end else if (cfg_load) begin
            pend       <= cfg_in;
            pend_valid <= 1'b1;
        end
    end

endmodule
